// File: rtl/hemaia_clock_divider_sequencer.sv
// Divisor sequencer placed directly upstream of the HeMAiA clock divider.
// Accepts divisor-change requests over valid/ready and either jumps straight
// to the target or ramps toward it in bounded steps, holding each issued
// divisor stable for HoldCycles cycles so the divider can pick it up lazily.
//
// Ports:
//   clk_i             undivided source clock (same as the divider's clk_i)
//   rst_i             asynchronous active-high reset
//   req_valid_i       new divisor request
//   req_ready_o       request accepted when high with req_valid_i (idle only)
//   req_divisor_i     target divisor, 0 gates the clock
//   ramp_en_i         sampled at acceptance: 1 = stepped ramp, 0 = direct jump
//   divisor_o         registered divisor to the divider
//   divisor_valid_o   registered single-cycle pulse qualifying divisor_o
//   current_divisor_o last issued divisor
//   busy_o            high while a step is issued or settling
//   done_o            single-cycle pulse when a request completes
module hemaia_clock_divider_sequencer #(
  parameter int unsigned MaxDivisionWidth = 4,
  parameter int unsigned DefaultDivision  = 1,
  parameter int unsigned StepSize         = 1,
  parameter int unsigned HoldCycles       = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [MaxDivisionWidth-1:0] req_divisor_i,
  input  logic                        ramp_en_i,
  output logic [MaxDivisionWidth-1:0] divisor_o,
  output logic                        divisor_valid_o,
  output logic [MaxDivisionWidth-1:0] current_divisor_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned W        = MaxDivisionWidth;
  localparam int unsigned CntWidth = $clog2(HoldCycles + 1);

  localparam logic [W-1:0]        DefDiv   = W'(DefaultDivision);
  localparam logic [W:0]          StepExt  = (W + 1)'(StepSize);
  localparam logic [CntWidth-1:0] HoldLoad = CntWidth'(HoldCycles);
  localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);

  typedef enum logic [1:0] {StIdle, StStep, StHold} state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        target_q, target_d;
  logic                ramp_q, ramp_d;
  logic [W-1:0]        cur_q, cur_d;
  logic [W-1:0]        div_q, div_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [W-1:0]        hold_step;
  logic [W-1:0]        idle_step;

  // Sums and differences are formed one bit wider so neither can wrap.
  function automatic logic [W-1:0] next_step(input logic [W-1:0] cur,
                                             input logic [W-1:0] tgt,
                                             input logic         ramp);
    logic [W:0]   cur_x;
    logic [W:0]   tgt_x;
    logic [W:0]   sum;
    logic [W:0]   diff;
    logic [W-1:0] ns;
    cur_x = {1'b0, cur};
    tgt_x = {1'b0, tgt};
    sum   = cur_x + StepExt;
    diff  = cur_x - tgt_x;
    // Gating and un-gating always jump directly.
    if (!ramp || (cur == '0) || (tgt == '0)) begin
      ns = tgt;
    end else if (tgt_x > cur_x) begin
      ns = (sum >= tgt_x) ? tgt : sum[W-1:0];
    end else begin
      ns = (diff <= StepExt) ? tgt : (cur - StepExt[W-1:0]);
    end
    return ns;
  endfunction

  assign hold_step = next_step(cur_q, target_q, ramp_q);
  assign idle_step = next_step(cur_q, req_divisor_i, ramp_en_i);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    ramp_d   = ramp_q;
    cur_d    = cur_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          target_d = req_divisor_i;
          ramp_d   = ramp_en_i;
          if (req_divisor_i == cur_q) begin
            done_d = 1'b1;
          end else begin
            div_d   = idle_step;
            cur_d   = idle_step;
            state_d = StStep;
          end
        end
      end
      StStep: begin
        cnt_d   = HoldLoad;
        state_d = StHold;
      end
      StHold: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          if (cur_q != target_q) begin
            div_d   = hold_step;
            cur_d   = hold_step;
            state_d = StStep;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered outputs follow the state being entered.
    valid_d = (state_d == StStep);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      target_q <= DefDiv;
      ramp_q   <= 1'b0;
      cur_q    <= DefDiv;
      div_q    <= DefDiv;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      ramp_q   <= ramp_d;
      cur_q    <= cur_d;
      div_q    <= div_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready_o       = (state_q == StIdle);
  assign divisor_o         = div_q;
  assign divisor_valid_o   = valid_q;
  assign current_divisor_o = cur_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;

endmodule

// File: tb/tb_hemaia_clock_divider_sequencer.sv
// Directed bench for hemaia_clock_divider_sequencer: one default instance
// (StepSize 1, HoldCycles 16) and one with StepSize 4.
module tb_hemaia_clock_divider_sequencer;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_div;
  logic       ramp_en;
  logic [3:0] div;
  logic       dvalid;
  logic [3:0] cur;
  logic       busy;
  logic       done;

  logic       r4_valid;
  logic       r4_ready;
  logic [3:0] r4_div;
  logic       r4_ramp;
  logic [3:0] div4;
  logic       dvalid4;
  logic [3:0] cur4;
  logic       busy4;
  logic       done4;

  int n_cmp = 0;
  int n_err = 0;

  hemaia_clock_divider_sequencer #(
    .MaxDivisionWidth(4),
    .DefaultDivision (1),
    .StepSize        (1),
    .HoldCycles      (16)
  ) u_dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_divisor_i    (req_div),
    .ramp_en_i        (ramp_en),
    .divisor_o        (div),
    .divisor_valid_o  (dvalid),
    .current_divisor_o(cur),
    .busy_o           (busy),
    .done_o           (done)
  );

  hemaia_clock_divider_sequencer #(
    .MaxDivisionWidth(4),
    .DefaultDivision (1),
    .StepSize        (4),
    .HoldCycles      (16)
  ) u_dut4 (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (r4_valid),
    .req_ready_o      (r4_ready),
    .req_divisor_i    (r4_div),
    .ramp_en_i        (r4_ramp),
    .divisor_o        (div4),
    .divisor_valid_o  (dvalid4),
    .current_divisor_o(cur4),
    .busy_o           (busy4),
    .done_o           (done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Handshake on the next edge; returns in the cycle right after it.
  task automatic request(input logic [3:0] d, input logic r);
    chk1("ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1;
    req_div   = d;
    ramp_en   = r;
    adv();
    req_valid = 1'b0;
  endtask

  // Called in a pulse cycle; returns HoldCycles+1 cycles later.
  task automatic pulse_hold(input logic [3:0] exp);
    chk1("pulse_valid", dvalid, 1'b1);
    chk4("pulse_div", div, exp);
    chk1("pulse_busy", busy, 1'b1);
    chk4("pulse_cur", cur, exp);
    repeat (16) begin
      adv();
      chk1("hold_valid", dvalid, 1'b0);
      chk4("hold_div", div, exp);
      chk1("hold_done", done, 1'b0);
      chk1("hold_ready", req_ready, 1'b0);
    end
    adv();
  endtask

  task automatic req4(input logic [3:0] d, input logic r);
    chk1("r4_ready", r4_ready, 1'b1);
    r4_valid = 1'b1;
    r4_div   = d;
    r4_ramp  = r;
    adv();
    r4_valid = 1'b0;
  endtask

  task automatic p4(input logic [3:0] exp);
    chk1("r4_pulse_valid", dvalid4, 1'b1);
    chk4("r4_pulse_div", div4, exp);
    chk1("r4_busy", busy4, 1'b1);
    repeat (17) adv();
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_div   = 4'd0;
    ramp_en   = 1'b0;
    r4_valid  = 1'b0;
    r4_div    = 4'd0;
    r4_ramp   = 1'b0;

    // Asynchronous reset asserted mid-cycle, checked before any edge.
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk4("rst_div", div, 4'd1);
    chk1("rst_valid", dvalid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ready", req_ready, 1'b1);
    chk4("rst_cur", cur, 4'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    adv();

    // Upward ramp 1 -> 5: pulses 2,3,4,5 at +1,+18,+35,+52, done at +69.
    request(4'd5, 1'b1);
    for (int s = 0; s < 4; s++) pulse_hold(4'(2 + s));
    chk1("up_done", done, 1'b1);
    chk1("up_busy", busy, 1'b0);
    chk4("up_cur", cur, 4'd5);
    adv();
    chk1("up_done_single", done, 1'b0);

    // Direct jump 5 -> 2, done at +18.
    request(4'd2, 1'b0);
    pulse_hold(4'd2);
    chk1("jump_done", done, 1'b1);

    // Gating: 2 -> 3 direct, ramp 3 -> 0, ramp 0 -> 3, each a single pulse.
    request(4'd3, 1'b0);
    pulse_hold(4'd3);
    chk1("pre_gate_done", done, 1'b1);
    request(4'd0, 1'b1);
    pulse_hold(4'd0);
    chk1("gate_done", done, 1'b1);
    chk4("gate_cur", cur, 4'd0);
    request(4'd3, 1'b1);
    pulse_hold(4'd3);
    chk1("ungate_done", done, 1'b1);
    chk4("ungate_cur", cur, 4'd3);

    // No change: no pulse, done at +1, busy stays low.
    request(4'd3, 1'b1);
    chk1("nochg_done", done, 1'b1);
    chk1("nochg_valid", dvalid, 1'b0);
    chk1("nochg_busy", busy, 1'b0);
    chk4("nochg_div", div, 4'd3);

    // Backpressure: a request held while busy is taken in the done cycle.
    adv();
    request(4'd4, 1'b1);
    req_valid = 1'b1;
    req_div   = 4'd6;
    ramp_en   = 1'b0;
    chk1("bp_pulse_valid", dvalid, 1'b1);
    chk4("bp_pulse_div", div, 4'd4);
    repeat (16) begin
      adv();
      chk1("bp_ready", req_ready, 1'b0);
      chk1("bp_valid", dvalid, 1'b0);
      chk4("bp_div", div, 4'd4);
    end
    adv();
    chk1("bp_done", done, 1'b1);
    chk1("bp_ready_done", req_ready, 1'b1);
    chk4("bp_div_done", div, 4'd4);
    adv();
    req_valid = 1'b0;
    chk1("bp_done_low", done, 1'b0);
    pulse_hold(4'd6);
    chk1("bp2_done", done, 1'b1);
    chk4("bp2_cur", cur, 4'd6);

    // Reset during the second hold of a 1 -> 5 ramp.
    request(4'd1, 1'b0);
    pulse_hold(4'd1);
    chk1("prep_done", done, 1'b1);
    request(4'd5, 1'b1);
    pulse_hold(4'd2);
    chk1("mr_valid", dvalid, 1'b1);
    chk4("mr_div", div, 4'd3);
    repeat (3) adv();
    chk1("mr_busy", busy, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk4("mr_rst_div", div, 4'd1);
    chk4("mr_rst_cur", cur, 4'd1);
    chk1("mr_rst_busy", busy, 1'b0);
    chk1("mr_rst_ready", req_ready, 1'b1);
    chk1("mr_rst_done", done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      adv();
      chk1("mr_no_done", done, 1'b0);
      chk1("mr_no_valid", dvalid, 1'b0);
      chk4("mr_div_idle", div, 4'd1);
    end
    request(4'd3, 1'b1);
    pulse_hold(4'd2);
    pulse_hold(4'd3);
    chk1("mr_fresh_done", done, 1'b1);
    chk4("mr_fresh_cur", cur, 4'd3);

    // StepSize 4: 1 -> 14 direct, ramp 14 -> 15 with no wrap, ramp 15 -> 2.
    req4(4'd14, 1'b0);
    p4(4'd14);
    chk1("s4_jump_done", done4, 1'b1);
    req4(4'd15, 1'b1);
    p4(4'd15);
    chk1("s4_up_done", done4, 1'b1);
    chk4("s4_up_cur", cur4, 4'd15);
    req4(4'd2, 1'b1);
    p4(4'd11);
    p4(4'd7);
    p4(4'd3);
    p4(4'd2);
    chk1("s4_down_done", done4, 1'b1);
    chk4("s4_down_cur", cur4, 4'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
